// File: rtl/add_mop_csv_pipe_if.sv
// Handshake bundle for add_mop_csv_pipe: operand beats in, carry-save results out.
interface add_mop_csv_pipe_if #(
    parameter int unsigned width = 16,
    parameter int unsigned depth = 6,
    parameter int unsigned cntw  = 8
);
    logic [depth*width-1:0] A;
    logic                   valid_i;
    logic                   last_i;
    logic                   ready_o;
    logic [width-1:0]       S;
    logic [width-1:0]       C;
    logic [cntw-1:0]        nbeats_o;
    logic                   valid_o;
    logic                   ready_i;

    modport master (
        output A, valid_i, last_i, ready_i,
        input  ready_o, S, C, nbeats_o, valid_o
    );

    modport slave (
        input  A, valid_i, last_i, ready_i,
        output ready_o, S, C, nbeats_o, valid_o
    );
endinterface

// File: rtl/add_mop_csv_pipe.sv
// Elastic multi-operand carry-save adder/accumulator: each beat is compressed to (s,c),
// pipelined, and folded into a carry-save accumulator until a beat tagged last closes it.
module add_mop_csv_pipe #(
    parameter int unsigned width  = 16,
    parameter int unsigned depth  = 6,
    parameter int unsigned stages = 2,
    parameter int unsigned cntw   = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    add_mop_csv_pipe_if.slave bus
);
    localparam int unsigned last_stage = stages - 1;

    // Majority of three vectors, moved up one slice; the top carry falls off.
    function automatic logic [width-1:0] maj_sh(input logic [width-1:0] x,
                                                input logic [width-1:0] y,
                                                input logic [width-1:0] z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    logic [width-1:0]  tree_s, tree_c, tree_op, tree_nc;
    logic [width-1:0]  ps [stages];
    logic [width-1:0]  pc [stages];
    logic [stages-1:0] pv, pl, adv;
    logic              gap;

    logic [width-1:0]  sa, ca;
    logic [cntw-1:0]   cnt;
    logic              pend;

    logic              fold, handoff;
    logic [width-1:0]  base_s, base_c, t_s, t_c, f_s, f_c;
    logic [cntw-1:0]   base_n, n_cnt;

    // Chain of bit-sliced 3:2 compressors reducing depth operands to one (s,c) pair.
    always_comb begin
        tree_op = '0;
        tree_nc = '0;
        tree_s  = bus.A[0 +: width];
        tree_c  = bus.A[width +: width];
        for (int k = 2; k < int'(depth); k++) begin
            tree_op = bus.A[k*width +: width];
            tree_nc = maj_sh(tree_s, tree_c, tree_op);
            tree_s  = tree_s ^ tree_c ^ tree_op;
            tree_c  = tree_nc;
        end
    end

    assign handoff = pend & bus.ready_i;
    assign fold    = pv[last_stage] & (~pend | bus.ready_i);

    // A stage may move when any stage at or after it has a hole, or the accumulator folds.
    always_comb begin
        adv = '0;
        gap = fold;
        for (int k = int'(stages) - 1; k >= 0; k--) begin
            gap    = gap | ~pv[k];
            adv[k] = gap;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pv <= '0;
            pl <= '0;
            for (int k = 0; k < int'(stages); k++) begin
                ps[k] <= '0;
                pc[k] <= '0;
            end
        end else begin
            if (adv[0]) begin
                pv[0] <= bus.valid_i;
                pl[0] <= bus.last_i;
                ps[0] <= tree_s;
                pc[0] <= tree_c;
            end
            for (int k = 1; k < int'(stages); k++) begin
                if (adv[k]) begin
                    pv[k] <= pv[k-1];
                    pl[k] <= pl[k-1];
                    ps[k] <= ps[k-1];
                    pc[k] <= pc[k-1];
                end
            end
        end
    end

    // 4:2 fold of {Sa,Ca,s,c}; a result handed off this cycle restarts the sum from zero.
    always_comb begin
        base_s = handoff ? '0 : sa;
        base_c = handoff ? '0 : ca;
        base_n = handoff ? '0 : cnt;
        t_s    = base_s ^ base_c ^ ps[last_stage];
        t_c    = maj_sh(base_s, base_c, ps[last_stage]);
        f_s    = t_s ^ t_c ^ pc[last_stage];
        f_c    = maj_sh(t_s, t_c, pc[last_stage]);
        n_cnt  = (base_n == {cntw{1'b1}}) ? base_n : base_n + cntw'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sa   <= '0;
            ca   <= '0;
            cnt  <= '0;
            pend <= 1'b0;
        end else if (fold) begin
            sa   <= f_s;
            ca   <= f_c;
            cnt  <= n_cnt;
            pend <= pl[last_stage];
        end else if (handoff) begin
            sa   <= '0;
            ca   <= '0;
            cnt  <= '0;
            pend <= 1'b0;
        end
    end

    assign bus.ready_o  = adv[0];
    assign bus.S        = sa;
    assign bus.C        = ca;
    assign bus.nbeats_o = cnt;
    assign bus.valid_o  = pend;
endmodule

// File: tb/tb_add_mop_csv_pipe.sv
// Bench for add_mop_csv_pipe: two instances (cntw 8 and 2) share stimulus; a sum/count
// scoreboard built from accepted beats checks every emitted result.
module tb_add_mop_csv_pipe;
    localparam int unsigned W  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned ST = 2;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a     = '0;
    logic        valid = 1'b0;
    logic        last  = 1'b0;
    logic        rdy   = 1'b1;

    always #5 clk = ~clk;

    add_mop_csv_pipe_if #(.width(W), .depth(D), .cntw(8)) b0 ();
    add_mop_csv_pipe_if #(.width(W), .depth(D), .cntw(2)) b1 ();

    assign b0.A = a;  assign b0.valid_i = valid;  assign b0.last_i = last;  assign b0.ready_i = rdy;
    assign b1.A = a;  assign b1.valid_i = valid;  assign b1.last_i = last;  assign b1.ready_i = rdy;

    add_mop_csv_pipe #(.width(W), .depth(D), .stages(ST), .cntw(8)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(b0.slave));
    add_mop_csv_pipe #(.width(W), .depth(D), .stages(ST), .cntw(2)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(b1.slave));

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(string name, longint act, longint want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endfunction

    // Model state: running sum/count of accepted beats, expected results in order.
    int msum = 0, mcnt = 0, nacc = 0, nres = 0, nvcyc = 0;
    int cyc = 0, rise_edge = 0, acc_edge_last = 0;
    int eq_sum[$], eq_cnt[$], rcv_sum[$], rcv_nb0[$], rcv_nb1[$];
    logic       prev_v = 1'b0, prev_hs = 1'b0;
    logic [7:0] prev_s = '0, prev_c = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            msum = 0; mcnt = 0;
            eq_sum.delete(); eq_cnt.delete();
            prev_v = 1'b0; prev_hs = 1'b0;
        end else begin
            if (prev_v && !prev_hs) begin
                chk("hold_valid", b0.valid_o, 1);
                chk("hold_S", b0.S, prev_s);
                chk("hold_C", b0.C, prev_c);
            end
            if (b0.valid_o) begin
                nvcyc++;
                if (!prev_v) rise_edge = cyc;
                chk("c_lsb_u0", b0.C[0], 0);
                chk("c_lsb_u1", b1.C[0], 0);
                chk("valid_u1", b1.valid_o, 1);
            end
            if (b0.valid_o && rdy) begin
                chk("result_expected", eq_sum.size() > 0, 1);
                if (eq_sum.size() > 0) begin
                    int es, ec;
                    es = eq_sum.pop_front();
                    ec = eq_cnt.pop_front();
                    chk("sum_u0", 8'(b0.S + b0.C), es);
                    chk("sum_u1", 8'(b1.S + b1.C), es);
                    chk("nbeats_u0", b0.nbeats_o, (ec > 255) ? 255 : ec);
                    chk("nbeats_u1", b1.nbeats_o, (ec > 3) ? 3 : ec);
                end
                rcv_sum.push_back(int'(8'(b0.S + b0.C)));
                rcv_nb0.push_back(int'(b0.nbeats_o));
                rcv_nb1.push_back(int'(b1.nbeats_o));
                nres++;
            end
            prev_v  = b0.valid_o;
            prev_hs = b0.valid_o & rdy;
            prev_s  = b0.S;
            prev_c  = b0.C;

            if (valid && b0.ready_o) begin
                nacc++;
                mcnt++;
                for (int k = 0; k < int'(D); k++) msum += int'(a[k*8 +: 8]);
                if (last) begin
                    eq_sum.push_back(msum % 256);
                    eq_cnt.push_back(mcnt);
                    acc_edge_last = cyc + 1;
                    msum = 0;
                    mcnt = 0;
                end
            end
        end
    end

    task automatic send(input int o0, input int o1, input int o2, input int o3, input logic l);
        int t = 0;
        a     = {8'(o3), 8'(o2), 8'(o1), 8'(o0)};
        valid = 1'b1;
        last  = l;
        @(negedge clk);
        while (!b0.ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("send_accepted", t < 200, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((eq_sum.size() != 0 || b0.valid_o) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_done", t < 100, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, v0, n0;
        logic [15:0] pat;
        logic [11:0] lasts;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", b0.valid_o, 0);
        chk("rst_S", b0.S, 0);
        chk("rst_C", b0.C, 0);
        chk("rst_nbeats", b0.nbeats_o, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat, latency and pulse width
        r0 = nres; v0 = nvcyc;
        send(1, 2, 3, 4, 1); idle(); drain();
        chk("t1_count", nres - r0, 1);
        chk("t1_sum", rcv_sum[r0], 10);
        chk("t1_nbeats", rcv_nb0[r0], 1);
        chk("t1_latency", rise_edge - acc_edge_last, 2);
        chk("t1_valid_cycles", nvcyc - v0, 1);

        // Three saturated-value beats
        r0 = nres;
        send(255, 255, 255, 255, 0);
        send(255, 255, 255, 255, 0);
        send(255, 255, 255, 255, 1);
        idle(); drain();
        chk("t2_count", nres - r0, 1);
        chk("t2_sum", rcv_sum[r0], 244);
        chk("t2_nbeats", rcv_nb0[r0], 3);

        // Backpressure: 20 per-beat results with a 6-cycle stall
        r0 = nres; n0 = nacc;
        rdy = 1'b0;
        fork
            begin
                for (int k = 1; k <= 20; k++) send(k, k, k, k, 1);
                idle();
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("t3_ready_low", b0.ready_o, 0);
                chk("t3_buffered", nacc - n0, 3);
                chk("t3_pending_sum", 8'(b0.S + b0.C), 4);
                rdy = 1'b1;
            end
        join
        drain();
        chk("t3_count", nres - r0, 20);
        for (int k = 1; k <= 20; k++) begin
            if (nres - r0 >= k) begin
                chk("t3_order", rcv_sum[r0 + k - 1], (4 * k) % 256);
                chk("t3_nbeats", rcv_nb0[r0 + k - 1], 1);
            end
        end

        // Hand-off cycle folds the next beat from zero
        r0 = nres;
        send(1, 1, 1, 1, 1); send(2, 2, 2, 2, 1); idle(); drain();
        chk("t4_count", nres - r0, 2);
        chk("t4_sum_a", rcv_sum[r0], 4);
        chk("t4_sum_b", rcv_sum[r0 + 1], 8);
        chk("t4_nb_a", rcv_nb0[r0], 1);
        chk("t4_nb_b", rcv_nb0[r0 + 1], 1);

        // Reset with two beats in flight and one accumulated
        send(9, 9, 9, 9, 0); send(9, 9, 9, 9, 0); send(9, 9, 9, 9, 0);
        idle();
        chk("t5_acc_before", b0.nbeats_o, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_S", b0.S, 0);
        chk("t5_rst_C", b0.C, 0);
        chk("t5_rst_valid", b0.valid_o, 0);
        chk("t5_rst_nb0", b0.nbeats_o, 0);
        chk("t5_rst_nb1", b1.nbeats_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        r0 = nres;
        send(5, 0, 0, 0, 1); idle(); drain();
        chk("t5_count", nres - r0, 1);
        chk("t5_sum", rcv_sum[r0], 5);
        chk("t5_nbeats", rcv_nb0[r0], 1);

        // Beat counter saturation on the narrow instance
        r0 = nres;
        for (int k = 0; k < 4; k++) send(1, 0, 0, 0, 0);
        send(1, 0, 0, 0, 1);
        idle(); drain();
        chk("t6_sum", rcv_sum[r0], 5);
        chk("t6_nb_wide", rcv_nb0[r0], 5);
        chk("t6_nb_sat", rcv_nb1[r0], 3);

        // Irregular downstream ready with mixed last tags
        r0 = nres;
        pat   = 16'b1011_0010_1110_0101;
        lasts = 12'b1010_0110_0101;
        fork
            begin
                for (int k = 0; k < 12; k++) send(k + 1, k + 10, 3 * k, 200, lasts[k]);
                idle();
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk);
                    #1;
                    rdy = pat[i % 16];
                end
                rdy = 1'b1;
            end
        join
        drain();
        chk("t7_count", nres - r0, 6);

        chk("leftover_results", eq_sum.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
